// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with enable prescaler, synchronous clear/load,
// wrap-or-saturate boundary handling and a registered boundary-event pulse.
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX      = 2**WIDTH - 1,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enb,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_zero,
    output logic             evt
);

    if (WIDTH < 2 || MAX == 0 || (MAX >> WIDTH) != 0 || PRESCALE == 0) begin : g_bad_param
        $error("updown_mod_counter: illegal parameters WIDTH=%0d MAX=%0d PRESCALE=%0d",
               WIDTH, MAX, PRESCALE);
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_q;
    logic             r_evt;
    logic             w_ps_last;
    logic             w_step;
    logic [WIDTH-1:0] w_step_q;
    logic             w_bound;
    logic [WIDTH-1:0] w_load_q;

    // Prescaler: counts enabled cycles, restarts on any clear/load/reset.
    if (PRESCALE > 1) begin : g_ps
        localparam int unsigned    PS_W    = $clog2(PRESCALE);
        localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
        logic [PS_W-1:0] r_ps;

        always_ff @(posedge clk) begin
            if (rst || clr || load) begin
                r_ps <= '0;
            end else if (enb) begin
                r_ps <= (r_ps == PS_LAST) ? '0 : r_ps + PS_W'(1);
            end
        end

        assign w_ps_last = (r_ps == PS_LAST);
    end else begin : g_no_ps
        assign w_ps_last = 1'b1;
    end

    assign w_step   = enb & w_ps_last;
    assign w_load_q = (load_val > MAX_V) ? MAX_V : load_val;

    // Next count for a step, flagging boundary crossings in either direction.
    always_comb begin
        w_step_q = r_q;
        w_bound  = 1'b0;
        if (up) begin
            if (r_q == MAX_V) begin
                w_bound = 1'b1;
                if (SATURATE == 0) begin
                    w_step_q = '0;
                end
            end else begin
                w_step_q = r_q + WIDTH'(1);
            end
        end else begin
            if (r_q == '0) begin
                w_bound = 1'b1;
                if (SATURATE == 0) begin
                    w_step_q = MAX_V;
                end
            end else begin
                w_step_q = r_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q   <= '0;
            r_evt <= 1'b0;
        end else if (load) begin
            r_q   <= w_load_q;
            r_evt <= 1'b0;
        end else if (w_step) begin
            r_q   <= w_step_q;
            r_evt <= w_bound;
        end else begin
            r_evt <= 1'b0;
        end
    end

    assign q       = r_q;
    assign evt     = r_evt;
    assign at_max  = (r_q == MAX_V);
    assign at_zero = (r_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three configurations share one directed stimulus
// stream; a per-cycle model plus hand-computed pins check every instance.
module tb_updown_mod_counter;

    localparam int unsigned W = 4;
    localparam int NI = 3;
    // Instance configs: 0 = wrap, 1 = saturate, 2 = wrap with prescale 3
    localparam int MAXS [NI] = '{9, 9, 9};
    localparam int SATS [NI] = '{0, 1, 0};
    localparam int PSS  [NI] = '{1, 1, 3};

    logic         clk = 1'b0;
    logic         rst, clr, load, enb, up;
    logic [W-1:0] load_val;
    logic [W-1:0] dq    [NI];
    logic         dmax  [NI];
    logic         dzero [NI];
    logic         devt  [NI];

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(W), .MAX(9), .SATURATE(0), .PRESCALE(1)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .enb(enb), .up(up),
        .q(dq[0]), .at_max(dmax[0]), .at_zero(dzero[0]), .evt(devt[0]));
    updown_mod_counter #(.WIDTH(W), .MAX(9), .SATURATE(1), .PRESCALE(1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .enb(enb), .up(up),
        .q(dq[1]), .at_max(dmax[1]), .at_zero(dzero[1]), .evt(devt[1]));
    updown_mod_counter #(.WIDTH(W), .MAX(9), .SATURATE(0), .PRESCALE(3)) u_ps (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .enb(enb), .up(up),
        .q(dq[2]), .at_max(dmax[2]), .at_zero(dzero[2]), .evt(devt[2]));

    // Behavioural model: count value, enabled-cycle tally, event flag.
    int m_q   [NI];
    int m_cnt [NI];
    int m_evt [NI];

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            m_evt[k] = 0;
            if (rst || clr) begin
                m_q[k]   = 0;
                m_cnt[k] = 0;
            end else if (load) begin
                m_q[k]   = (int'(load_val) > MAXS[k]) ? MAXS[k] : int'(load_val);
                m_cnt[k] = 0;
            end else if (enb) begin
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == PSS[k]) begin
                    bit at_edge;
                    int nxt;
                    m_cnt[k] = 0;
                    at_edge  = up ? (m_q[k] == MAXS[k]) : (m_q[k] == 0);
                    nxt      = up ? (m_q[k] + 1) % (MAXS[k] + 1)
                                  : (m_q[k] + MAXS[k]) % (MAXS[k] + 1);
                    m_evt[k] = at_edge ? 1 : 0;
                    if (!(at_edge && SATS[k] != 0)) m_q[k] = nxt;
                end
            end
        end
    end

    typedef struct {
        bit rst, clr, load;
        int lv;
        bit enb, up;
        int li, lq, le;
    } vec_t;
    vec_t vq[$];

    bit chk_en = 1'b0;
    int lit_i  = -1;
    int lit_q  = 0;
    int lit_e  = 0;
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s inst%0d at %0t: got %0d expected %0d", nm, k, $time, act, exp);
        end
    endtask

    // Single compare process: model on every cycle, plus any literal pin.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                chk("q",       k, int'(dq[k]),    m_q[k]);
                chk("evt",     k, int'(devt[k]),  m_evt[k]);
                chk("at_max",  k, int'(dmax[k]),  (m_q[k] == MAXS[k]) ? 1 : 0);
                chk("at_zero", k, int'(dzero[k]), (m_q[k] == 0) ? 1 : 0);
            end
            if (lit_i >= 0) begin
                chk("pin_q",   lit_i, int'(dq[lit_i]),   lit_q);
                chk("pin_evt", lit_i, int'(devt[lit_i]), lit_e);
            end
        end
    end

    task automatic add(input bit r, input bit c, input bit l, input int lv, input bit e, input bit u);
        vec_t v;
        v.rst = r; v.clr = c; v.load = l; v.lv = lv; v.enb = e; v.up = u;
        v.li = -1; v.lq = 0; v.le = 0;
        vq.push_back(v);
    endtask

    task automatic pin(input int k, input int qv, input int ev);
        vq[vq.size()-1].li = k;
        vq[vq.size()-1].lq = qv;
        vq[vq.size()-1].le = ev;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; enb = 1'b0; up = 1'b1;

        // Reset
        add(1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1); pin(0, 0, 0);
        // Wrap up 1..9,0,1,2; saturating instance sticks at 9 with evt
        for (int i = 1; i <= 12; i++) begin
            add(0, 0, 0, 0, 1, 1);
            if (i == 1)  pin(0, 1, 0);
            if (i == 9)  pin(0, 9, 0);
            if (i == 10) pin(0, 0, 1);
            if (i == 11) pin(1, 9, 1);
            if (i == 12) pin(0, 2, 0);
        end
        // Wrap down from 2: 1,0,9,8
        add(0, 0, 1, 2, 0, 1); pin(0, 2, 0);
        for (int i = 1; i <= 4; i++) begin
            add(0, 0, 0, 0, 1, 0);
            if (i == 1) pin(0, 1, 0);
            if (i == 3) pin(0, 9, 1);
            if (i == 4) pin(0, 8, 0);
        end
        // Saturate up from 8: 9,9,9 with evt on 2nd and 3rd
        add(0, 0, 1, 8, 0, 1); pin(1, 8, 0);
        for (int i = 1; i <= 3; i++) begin
            add(0, 0, 0, 0, 1, 1);
            pin(1, 9, (i == 1) ? 0 : 1);
        end
        // Saturate down at zero keeps pulsing
        add(0, 1, 0, 0, 0, 1); pin(1, 0, 0);
        add(0, 0, 0, 0, 1, 0); pin(1, 0, 1);
        add(0, 0, 0, 0, 1, 0); pin(1, 0, 1);
        // Prescaler: steps on enabled cycles 3, 6, 9; gap preserves phase
        add(0, 1, 0, 0, 0, 1); pin(2, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            add(0, 0, 0, 0, 1, 1);
            if (i == 2) pin(2, 0, 0);
            if (i == 3) pin(2, 1, 0);
            if (i == 6) pin(2, 2, 0);
            if (i == 9) pin(2, 3, 0);
        end
        add(0, 0, 0, 0, 1, 1); pin(2, 3, 0);
        add(0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1); pin(2, 3, 0);
        add(0, 0, 0, 0, 1, 1); pin(2, 3, 0);
        add(0, 0, 0, 0, 1, 1); pin(2, 4, 0);
        // Priority (clr beats load/enb) and load clamp
        add(0, 1, 1, 15, 1, 1); pin(0, 0, 0);
        add(0, 0, 1, 15, 0, 1); pin(0, 9, 0);
        // Reset mid-prescale at q=5, prescaler phase 1
        add(0, 0, 1, 5, 0, 1); pin(2, 5, 0);
        add(0, 0, 0, 0, 1, 1); pin(2, 5, 0);
        add(1, 0, 0, 0, 1, 1); pin(2, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            add(0, 0, 0, 0, 1, 1);
            if (i == 2) pin(2, 0, 0);
            if (i == 3) pin(2, 1, 0);
        end

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            #1;
            rst      = vq[i].rst;
            clr      = vq[i].clr;
            load     = vq[i].load;
            load_val = W'(vq[i].lv);
            enb      = vq[i].enb;
            up       = vq[i].up;
            lit_i    = vq[i].li;
            lit_q    = vq[i].lq;
            lit_e    = vq[i].le;
            if (i == 1) chk_en = 1'b1;
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter with a built-in enable prescaler, synchronous load and clear, selectable wrap or saturate behaviour, and a registered boundary-event pulse. It is the general-purpose successor to the team's fixed 4-bit up-counter. It sits wherever timers, address generators or event tallies need a programmable modulus and direction.

## Interface
- WIDTH, 8: counter width in bits; ≥ 2.
- MAX, 2**WIDTH-1: terminal value; count range is 0..MAX; 1 ≤ MAX ≤ 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at boundaries, 1 = hold at boundaries.
- PRESCALE, 1: number of enabled cycles per count step; ≥ 1; 1 = step on every enabled cycle.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous clear of count and prescaler.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  load value; clamped to MAX if greater.
- enb  in  1  count enable; feeds the prescaler.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on each step.
- q  out  WIDTH  current count, registered.
- at_max  out  1  combinational, q == MAX.
- at_zero  out  1  combinational, q == 0.
- evt  out  1  registered one-cycle pulse on a boundary event.

## Operation
- Priority per cycle: rst > clr > load > enb. Only the highest-priority active input acts.
- rst: q=0, prescaler=0, evt=0.
- clr: q=0, prescaler=0, evt=0.
- load: q = min(load_val, MAX), prescaler=0, evt=0.
- enb with no higher-priority input: prescaler advances.
  - When prescaler == PRESCALE-1, a step occurs and the prescaler returns to 0.
  - Otherwise the prescaler increments and q holds.
- With PRESCALE=1 there is no prescaler register; every enabled cycle is a step.
- Step with up=1:
  - q<MAX: q+1.
  - q==MAX, SATURATE=0: q=0, evt=1.
  - q==MAX, SATURATE=1: q holds, evt=1.
- Step with up=0:
  - q>0: q-1.
  - q==0, SATURATE=0: q=MAX, evt=1.
  - q==0, SATURATE=1: q holds, evt=1.
- evt is 0 in every cycle not listed above. It pulses again on every further boundary step while saturated.
- enb=0: q and prescaler hold; evt=0.
- Arithmetic is WIDTH bits. No intermediate value exceeds MAX, so there is no overflow beyond MAX.
- Elaboration must reject illegal parameter values (MAX=0, MAX ≥ 2**WIDTH, PRESCALE=0, WIDTH<2).

## Timing
- All outputs come out of reset as q=0, evt=0, at_zero=1, at_max=0.
- Latency is one cycle: a step, load or clear sampled at edge N is visible on q after edge N.
- evt asserts in the same cycle q shows the post-wrap value (or the held value when saturating). It lasts exactly one cycle.
- at_max and at_zero follow q combinationally with zero added latency.
- Direction change: up toggling mid-count takes effect at the next step, with no dead cycle.
- load coinciding with enb: load wins and the prescaler phase restarts. First step after the load comes PRESCALE enabled cycles later.
- rst asserted mid-prescale or mid-count: full clear on that edge, no evt. Counting resumes on the first enabled cycle after rst deasserts.
- load_val > MAX: q=MAX, evt=0.

## Test plan
- Wrap up, WIDTH=4, MAX=9, PRESCALE=1, SATURATE=0: hold enb=1, up=1 for 12 cycles from reset -> q goes 1..9,0,1,2; evt high only in the cycle q=0.
- Wrap down, same config: load 2, then up=0 with enb for 4 cycles -> q goes 1,0,9,8; evt high with q=9.
- Saturate, SATURATE=1, MAX=9: load 8, up=1 with enb for 3 cycles -> q goes 9,9,9; evt high in the 2nd and 3rd cycles; at_max=1 from the first cycle.
- Prescaler, PRESCALE=3: enb=1 for 9 cycles from q=0 -> q steps only on cycles 3, 6 and 9. Drop enb for 2 cycles mid-phase -> the phase is preserved.
- Priority and clamp: assert load (load_val=15, MAX=9), clr and enb together -> q=0. Then load alone -> q=9, evt=0.
- Reset mid-operation: at q=5 with the prescaler at 1, assert rst for 1 cycle with enb=1 -> q=0, evt=0. The first step lands PRESCALE enabled cycles later.
